pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, multi-cycle MDU
// stalls (RUN/BUSY/HOLD FSM) and a saturating stalled-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memory_stall,
  input  logic             MemRead_2,
  input  logic [4:0]       Rd_2,
  input  logic [4:0]       Rs1_1,
  input  logic [4:0]       Rs2_1,
  input  logic             branch_taken_1,
  input  logic             mdu_req_2,
  input  logic             mdu_done,
  input  logic             cnt_clr,
  output logic             pipe_stall,
  output logic             stall_front,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, BUSY, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mdu_hold;
  logic             w_load_use;
  logic             w_pipe_stall;
  logic             w_bubble;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_next;
  end

  // Every output is forced low while reset is asserted so a half-finished
  // MDU operation cannot leak a stall or a launch pulse.
  always_comb begin
    w_state_next = r_state;
    w_mdu_hold   = 1'b0;
    w_load_use   = 1'b0;
    w_pipe_stall = 1'b0;
    w_bubble     = 1'b0;
    flush_ifid   = 1'b0;
    mdu_start    = 1'b0;

    case (r_state)
      RUN: begin
        if (mdu_req_2 && !memory_stall) begin
          w_state_next = BUSY;
          mdu_start    = rst_n;
        end
      end
      BUSY: begin
        w_mdu_hold = !mdu_done;
        if (mdu_done) w_state_next = memory_stall ? HOLD : RUN;
      end
      HOLD: begin
        w_mdu_hold = 1'b1;
        if (!memory_stall) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase

    w_load_use   = MemRead_2 && (Rd_2 != 5'd0) && ((Rd_2 == Rs1_1) || (Rd_2 == Rs2_1));
    w_pipe_stall = rst_n && (memory_stall || w_mdu_hold || ((r_state == RUN) && mdu_req_2));
    w_bubble     = rst_n && w_load_use && !w_pipe_stall;
    // A load-use stall postpones the flush until the branch operands arrive.
    flush_ifid   = rst_n && branch_taken_1 && !w_pipe_stall && !w_load_use;
  end

  assign pipe_stall  = w_pipe_stall;
  assign stall_front = w_bubble;
  assign bubble_idex = w_bubble;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr)
      r_cnt <= '0;
    else if ((w_pipe_stall || w_bubble) && (r_cnt != CNT_MAX))
      r_cnt <= r_cnt + CNT_ONE;
  end

  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a reference model predicts each
// cycle's outputs, the prediction is queued, then popped and compared.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             memory_stall;
  logic             MemRead_2;
  logic [4:0]       Rd_2;
  logic [4:0]       Rs1_1;
  logic [4:0]       Rs2_1;
  logic             branch_taken_1;
  logic             mdu_req_2;
  logic             mdu_done;
  logic             cnt_clr;
  logic             pipe_stall;
  logic             stall_front;
  logic             bubble_idex;
  logic             flush_ifid;
  logic             mdu_start;
  logic [CNT_W-1:0] stall_cnt;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall), .MemRead_2(MemRead_2),
    .Rd_2(Rd_2), .Rs1_1(Rs1_1), .Rs2_1(Rs2_1), .branch_taken_1(branch_taken_1),
    .mdu_req_2(mdu_req_2), .mdu_done(mdu_done), .cnt_clr(cnt_clr),
    .pipe_stall(pipe_stall), .stall_front(stall_front), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .mdu_start(mdu_start), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic             ps;
    logic             sf;
    logic             bi;
    logic             fl;
    logic             st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  // Reference model state: 0 = idle, 1 = waiting for MDU, 2 = done but memory stalled
  int               m_state;
  logic [CNT_W-1:0] m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL step=%0d %s observed=%0h expected=%0h", n_step, tag, obs, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic lu, waiting;
    waiting = (m_state == 1 && !mdu_done) || (m_state == 2);
    lu      = MemRead_2 && Rd_2 != 0 && (Rd_2 == Rs1_1 || Rd_2 == Rs2_1);
    e.ps    = rst_n && (memory_stall || waiting || (m_state == 0 && mdu_req_2));
    e.sf    = rst_n && lu && !e.ps;
    e.bi    = e.sf;
    e.fl    = rst_n && branch_taken_1 && !e.ps && !lu;
    e.st    = rst_n && m_state == 0 && mdu_req_2 && !memory_stall;
    e.cnt   = m_cnt;
    return e;
  endfunction

  task automatic advance_model(input exp_t e);
    if (!rst_n) begin
      m_state = 0;
      m_cnt   = 0;
    end else begin
      if (cnt_clr) m_cnt = 0;
      else if ((e.ps || e.bi) && m_cnt != 4'hF) m_cnt = m_cnt + 1;
      case (m_state)
        0: if (mdu_req_2 && !memory_stall) m_state = 1;
        1: if (mdu_done) m_state = memory_stall ? 2 : 0;
        default: if (!memory_stall) m_state = 0;
      endcase
    end
  endtask

  // One clock of stimulus: predict, queue, sample mid-cycle, compare, clock.
  task automatic step(input logic rn, input logic ms, input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic br,
                      input logic rq, input logic dn, input logic clr);
    exp_t e;
    exp_t got;
    rst_n = rn; memory_stall = ms; MemRead_2 = mr; Rd_2 = rd; Rs1_1 = r1; Rs2_1 = r2;
    branch_taken_1 = br; mdu_req_2 = rq; mdu_done = dn; cnt_clr = clr;
    e = predict();
    sb_q.push_back(e);
    #4;
    n_step++;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL step=%0d scoreboard observed=empty expected=entry", n_step);
    end else begin
      got = sb_q.pop_front();
      check_val("pipe_stall",  {31'd0, pipe_stall},  {31'd0, got.ps});
      check_val("stall_front", {31'd0, stall_front}, {31'd0, got.sf});
      check_val("bubble_idex", {31'd0, bubble_idex}, {31'd0, got.bi});
      check_val("flush_ifid",  {31'd0, flush_ifid},  {31'd0, got.fl});
      check_val("mdu_start",   {31'd0, mdu_start},   {31'd0, got.st});
      check_val("stall_cnt",   {28'd0, stall_cnt},   {28'd0, got.cnt});
    end
    $display("step=%0d rn=%b ms=%b lu_in=%b/%0d/%0d/%0d br=%b rq=%b dn=%b clr=%b -> ps=%b bub=%b fl=%b st=%b cnt=%0d",
             n_step, rn, ms, mr, rd, r1, r2, br, rq, dn, clr,
             pipe_stall, bubble_idex, flush_ifid, mdu_start, stall_cnt);
    @(posedge clk);
    advance_model(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; memory_stall = 0; MemRead_2 = 0; Rd_2 = 0; Rs1_1 = 0; Rs2_1 = 0;
    branch_taken_1 = 0; mdu_req_2 = 0; mdu_done = 0; cnt_clr = 0;
    @(posedge clk);
    @(negedge clk);
    m_state = 0;
    m_cnt   = 0;

    // reset with quiet inputs: everything low
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // load-use on Rs1, then on Rs2, then Rd=0 (no hazard), then mismatch
    step(1, 0, 1, 5, 5, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 1, 7, 1, 7, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 3, 4, 6, 0, 0, 0, 0);
    // load-use masked by memory stall
    step(1, 1, 1, 5, 5, 0, 0, 0, 0, 0);

    // branch alone, branch with load-use, branch during memory stall
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 9, 9, 2, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // MDU: launch, three busy cycles, done, then a new instruction
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);

    // launch blocked by memory stall, retried next cycle
    step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // done while memory stalled: HOLD for three stalled cycles
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // stray done in RUN is ignored
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // saturation: 20 stalled cycles, then clear beats a concurrent stall
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // reset in the middle of an MDU operation
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // random mix
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
